fetch_redirect: RTL

//  - IF-stage PC sequencer: holds PC, issues instruction-fetch requests, applies taken-branch/jump redirects.
//  - Consumes the jump decision from the EX-stage branch comparator plus its target (ALU result).
//  - Drives IF/ID and ID/EX flush pulses.
//  - Holds a redirect that arrives while imem is busy, so no redirect is ever lost.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_redirect_if.sv | 41 ++++
 rtl/fetch_redirect_hold.sv | 40 ++++
 rtl/fetch_redirect.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared core definitions for the fetch stage: datapath width,
//                reset/trap vectors and the fetch sequencer state encoding.
//  Contents    : XLEN, RESET_VECTOR, TRAP_VECTOR, fetch_state_t
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_MEM   = 2'd1,
        REDIR_PEND = 2'd2
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_redirect_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_if
//  Description : Bundle between the IF-stage PC sequencer and its neighbours
//                (EX redirect source, ID hazard unit, instruction memory and
//                the IF/ID, ID/EX pipeline registers).
//  Modports    : master - the fetch sequencer (drives *_o, samples *_i)
//                slave  - the surrounding pipeline / memory side
//  Signals     : jump_i, ex_valid_i, target_i, stall_i, imem_ready_i  (to seq)
//                imem_req_o, pc_o, pc_plus4_o, if_id_flush_o,
//                id_ex_flush_o, misalign_o                          (from seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_redirect_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            jump_i;
    logic            ex_valid_i;
    logic [XLEN-1:0] target_i;
    logic            stall_i;
    logic            imem_ready_i;
    logic            imem_req_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            if_id_flush_o;
    logic            id_ex_flush_o;
    logic            misalign_o;

    modport master (
        input  jump_i, ex_valid_i, target_i, stall_i, imem_ready_i,
        output imem_req_o, pc_o, pc_plus4_o, if_id_flush_o, id_ex_flush_o,
               misalign_o
    );

    modport slave (
        output jump_i, ex_valid_i, target_i, stall_i, imem_ready_i,
        input  imem_req_o, pc_o, pc_plus4_o, if_id_flush_o, id_ex_flush_o,
               misalign_o
    );
endinterface : fetch_redirect_if
`default_nettype wire

// File: rtl/fetch_redirect_hold.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_hold
//  Description : Pending-redirect register. Captures a redirect target that
//                could not be issued because imem was busy, and clears it once
//                the sequencer has consumed it.
//  Ports       : clk, rst_n           clock / async active-low reset
//                load_i, target_i     capture a new pending target
//                consume_i            pending target has been applied
//                pend_pc_o            currently held target
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_redirect_hold #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            load_i,
    input  wire logic [XLEN-1:0] target_i,
    input  wire logic            consume_i,
    output logic      [XLEN-1:0] pend_pc_o
);

    logic [XLEN-1:0] r_pend_pc;

    // A newer redirect always replaces an older one, so load wins over consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_pc <= '0;
        end else if (load_i) begin
            r_pend_pc <= target_i;
        end else if (consume_i) begin
            r_pend_pc <= '0;
        end
    end

    assign pend_pc_o = r_pend_pc;

endmodule : fetch_redirect_hold
`default_nettype wire

// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect
//  Description : IF-stage PC sequencer. Holds the PC, issues fetch requests,
//                applies EX-stage taken-branch/jump redirects, pulses the
//                IF/ID and ID/EX flushes, and parks a redirect that arrives
//                while imem is busy so it is never lost.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    fetch_redirect_if.master (see interface header)
//  Config      : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//                target with target_i[1:0]!=0 goes to TRAP_VECTOR and pulses
//                misalign_o; otherwise the low two target bits are masked.
//  Revision    : 1.0  initial release
// ============================================================================
import riscv_pkg::*;

module fetch_redirect #(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(riscv_pkg::TRAP_VECTOR)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fetch_redirect_if.master bus
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_active;      // low only in the first cycle out of reset
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pend_pc;
    logic            w_take;
    logic            w_misalign;
    logic            w_flush;
    logic            w_pend_load;
    logic            w_pend_consume;

    assign w_take     = bus.jump_i & bus.ex_valid_i & r_active;
    assign w_pc_plus4 = r_pc + XLEN'(4);   // wraps modulo 2^XLEN

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = |bus.target_i[1:0];
    assign w_redir_pc = w_misalign ? TRAP_VECTOR : bus.target_i;
`else
    // Low target bits and the trap vector are deliberately unused here.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{bus.target_i[1:0], TRAP_VECTOR};
    assign w_misalign   = 1'b0;
    assign w_redir_pc   = {bus.target_i[XLEN-1:2], 2'b00};
`endif

    // ------------------------------------------------------------------
    // State / PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_active <= 1'b0;
            r_pc     <= RESET_VECTOR;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
            r_pc     <= w_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / PC selection. Priority: redirect > stall > sequential.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_flush        = 1'b0;
        w_pend_load    = 1'b0;
        w_pend_consume = 1'b0;

        if (r_active) begin
            unique case (r_state)
                RUN, WAIT_MEM: begin
                    if (w_take) begin
                        w_flush = 1'b1;
                        if (bus.imem_ready_i) begin
                            w_pc_nxt    = w_redir_pc;
                            w_state_nxt = RUN;
                        end else begin
                            w_pend_load = 1'b1;
                            w_state_nxt = REDIR_PEND;
                        end
                    end else if (bus.imem_ready_i) begin
                        if (!bus.stall_i) begin
                            w_pc_nxt = w_pc_plus4;
                        end
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = WAIT_MEM;
                    end
                end

                REDIR_PEND: begin
                    // The stale request stays on the bus until imem takes it;
                    // the word it returns was already squashed by the flush.
                    if (w_take) begin
                        w_flush = 1'b1;
                        if (bus.imem_ready_i) begin
                            w_pc_nxt       = w_redir_pc;
                            w_pend_consume = 1'b1;
                            w_state_nxt    = RUN;
                        end else begin
                            w_pend_load = 1'b1;
                        end
                    end else if (bus.imem_ready_i) begin
                        w_pc_nxt       = w_pend_pc;
                        w_pend_consume = 1'b1;
                        w_state_nxt    = RUN;
                    end
                end

                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    fetch_redirect_hold #(
        .XLEN      (XLEN)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_pend_load),
        .target_i  (w_redir_pc),
        .consume_i (w_pend_consume),
        .pend_pc_o (w_pend_pc)
    );

    assign bus.imem_req_o    = r_active;
    assign bus.pc_o          = r_pc;
    assign bus.pc_plus4_o    = w_pc_plus4;
    assign bus.if_id_flush_o = w_flush;
    assign bus.id_ex_flush_o = w_flush;
    assign bus.misalign_o    = w_flush & w_misalign;

endmodule : fetch_redirect
`default_nettype wire
